// File: rtl/mem_pkg.sv
// Shared defaults and typedefs for the byte-wide single-port RAM.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 18;
    localparam int unsigned MEM_DATA_W = 8;
    localparam int unsigned MEM_DEPTH  = 2 ** MEM_ADDR_W;

    typedef logic [MEM_ADDR_W-1:0] addr_t;
    typedef logic [MEM_DATA_W-1:0] data_t;

endpackage

// File: rtl/mem_array.sv
// Reset-free storage array; write is synchronous, read is combinational so the
// caller owns the output register.
module mem_array #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory.sv
// Single-port synchronous RAM: enable decode plus a reset-clearable read-data
// register in front of the storage array.
module memory
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              cs,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              w_en,
    input  logic              r_en,
    output logic [DATA_W-1:0] d_out,
    input  logic              rst_n
);

    logic              we;
    logic              re;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] d_out_q;

    // Write has priority: a combined request never reads, so no read-during-write path.
    assign we = cs & w_en;
    assign re = cs & r_en & ~w_en;

    mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk  (clk),
        .we   (we & rst_n),
        .waddr(addr),
        .raddr(addr),
        .wdata(d_in),
        .rdata(rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out_q <= '0;
        end else if (re) begin
            d_out_q <= rdata;
        end
    end

    assign d_out = d_out_q;

endmodule

// File: tb/tb_memory.sv
// Directed plus randomised checks of memory against an associative-array model.
module tb_memory;
    import mem_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  cs;
    logic  w_en;
    logic  r_en;
    addr_t addr;
    data_t d_in;
    data_t d_out;

    memory u_dut (
        .clk  (clk),
        .cs   (cs),
        .addr (addr),
        .d_in (d_in),
        .w_en (w_en),
        .r_en (r_en),
        .d_out(d_out),
        .rst_n(rst_n)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Behavioural model: storage is a sparse map, d_out is simply "last value read".
    data_t ref_mem [addr_t];
    data_t exp_dout;
    bit    exp_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One bus cycle: drive at negedge, model the rising edge, compare #1 after it.
    task automatic step(input logic rst, input logic c, input logic w, input logic r,
                        input addr_t a, input data_t d);
        @(negedge clk);
        rst_n = rst; cs = c; w_en = w; r_en = r; addr = a; d_in = d;
        if (!rst) begin
            #1;
            check("rst_async", d_out, 0);
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            exp_dout  = '0;
            exp_known = 1'b1;
        end else if (c && w) begin
            ref_mem[a] = d;
        end else if (c && r) begin
            if (ref_mem.exists(a)) begin
                exp_dout  = ref_mem[a];
                exp_known = 1'b1;
            end else begin
                exp_known = 1'b0;
            end
        end
        if (exp_known) check("d_out", d_out, exp_dout);
    endtask

    task automatic wr(input addr_t a, input data_t d);
        step(1'b1, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input addr_t a);
        step(1'b1, 1'b1, 1'b0, 1'b1, a, '0);
    endtask

    addr_t pool [8];

    initial begin
        rst_n = 1'b1; cs = 1'b1; w_en = 1'b0; r_en = 1'b1; addr = '0; d_in = '0;
        exp_dout = '0; exp_known = 1'b1;

        // Reset asserted between edges must clear d_out without a clock.
        #3 rst_n = 1'b0;
        #1 check("rst_now", d_out, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 18'd0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 18'd1, 8'd0);

        // Write/read-back with a held address.
        wr(18'd0, 8'd7);
        wr(18'd1, 8'd10);
        wr(18'd2, 8'd2);
        wr(18'd3, 8'd5);
        wr(18'd3, 8'd5);
        wr(18'd4, 8'd12);
        for (int i = 0; i < 5; i++) rd(addr_t'(i));
        check("rd4_direct", d_out, 12);

        // Chip select low: no write, no read.
        step(1'b1, 1'b0, 1'b1, 1'b0, 18'd1, 8'd99);
        step(1'b1, 1'b0, 1'b0, 1'b1, 18'd0, 8'd0);
        check("cs_hold", d_out, 12);
        rd(18'd1);
        check("cs_nowrite", d_out, 10);

        // Both enables: write wins, output holds.
        step(1'b1, 1'b1, 1'b1, 1'b1, 18'd2, 8'd55);
        check("wr_prio_hold", d_out, 10);
        rd(18'd2);
        check("wr_prio_data", d_out, 55);

        // Address extremes, no aliasing.
        wr(18'h3FFFF, 8'hA5);
        wr(18'h00000, 8'h5A);
        rd(18'h3FFFF);
        check("addr_max", d_out, 8'hA5);
        rd(18'h00000);
        check("addr_min", d_out, 8'h5A);

        // Reset mid-burst; a write attempted under reset must be dropped.
        rd(18'd1);
        rd(18'd2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 18'd3, 8'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 18'd4, 8'd77);
        rd(18'd4);
        check("rst_preserve", d_out, 12);

        // Random traffic over a small address pool so reads often hit written data.
        pool[0] = 18'h00000;
        pool[1] = 18'h3FFFF;
        for (int i = 2; i < 8; i++) pool[i] = addr_t'($urandom);
        for (int i = 0; i < 8; i++) wr(pool[i], data_t'($urandom));
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 6),
                 pool[$urandom_range(0, 7)], data_t'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
